// File: rtl/wb_csr_bridge.sv
// Wishbone slave to CSR bus bridge: one word per transfer, writes ack in one
// cycle, reads hold csr_a for READ_WAIT cycles before sampling csr_di.
module wb_csr_bridge #(
    parameter int CSR_AW    = 14,  // 1..29
    parameter int READ_WAIT = 2    // 1..15
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic [2:0]        wb_cti_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [31:0]       csr_do,
    input  logic [31:0]       csr_di
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] RWAIT = 2'd2;
    localparam logic [1:0] RACK  = 2'd3;

    localparam logic [3:0] RW_INIT = 4'(READ_WAIT - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       req;

    assign req = wb_cyc_i & wb_stb_i;

    // Byte lanes, cycle type and out-of-window address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{wb_sel_i, wb_cti_i, wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0]};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wb_ack_o <= 1'b0;
            csr_we   <= 1'b0;
            csr_a    <= '0;
            csr_do   <= '0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            csr_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        csr_a  <= wb_adr_i[CSR_AW+1:2];
                        csr_do <= wb_dat_i;
                        if (wb_we_i) begin
                            // Strobe and ack are raised together so the write
                            // completes one cycle after the request is seen.
                            state    <= WRITE;
                            csr_we   <= 1'b1;
                            wb_ack_o <= 1'b1;
                        end else begin
                            state <= RWAIT;
                            cnt   <= RW_INIT;
                        end
                    end
                end
                WRITE: state <= IDLE;
                RWAIT: begin
                    // A master that gives up mid-read gets no ack and no data update.
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state    <= RACK;
                        wb_dat_o <= csr_di;
                        wb_ack_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RACK:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_csr_bridge.md
WB_CSR_BRIDGE -- requirements
Module: wb_csr_bridge

Interface
REQ-001 SHALL have parameter CSR_AW, default 14, CSR address width in words.
REQ-002 SHALL have parameter READ_WAIT, default 2, cycles csr_a is held before csr_di is sampled; legal range 1..15.
REQ-003 SHALL have port sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wb_adr_i  input  32  Wishbone byte address.
REQ-006 SHALL have port wb_dat_i  input  32  Wishbone write data.
REQ-007 SHALL have port wb_dat_o  output  32  Wishbone read data.
REQ-008 SHALL have port wb_sel_i  input  4  byte select; ignored.
REQ-009 SHALL have port wb_cti_i  input  3  cycle type; ignored.
REQ-010 SHALL have port wb_we_i  input  1  write enable.
REQ-011 SHALL have port wb_cyc_i  input  1  bus cycle.
REQ-012 SHALL have port wb_stb_i  input  1  strobe.
REQ-013 SHALL have port wb_ack_o  output  1  acknowledge.
REQ-014 SHALL have port csr_a  output  CSR_AW  CSR word address.
REQ-015 SHALL have port csr_we  output  1  CSR write strobe.
REQ-016 SHALL have port csr_do  output  32  CSR write data.
REQ-017 SHALL have port csr_di  input  32  CSR read data, OR of all CSR slaves.

Function
REQ-018 SHALL implement states IDLE, WRITE, RWAIT, RACK; all outputs registered, with no combinational path from any input to any output.
REQ-019 In IDLE, on wb_cyc_i & wb_stb_i, SHALL load csr_a <= wb_adr_i[CSR_AW+1:2] and csr_do <= wb_dat_i.
REQ-020 Also in IDLE on that request, SHALL go to WRITE if wb_we_i=1, otherwise go to RWAIT with wait counter loaded to READ_WAIT-1.
REQ-021 WRITE SHALL last exactly one cycle with csr_we=1 and wb_ack_o=1, then return to IDLE; write latency strobe-sample to ack SHALL be 1 cycle.
REQ-022 RWAIT SHALL hold csr_we=0 and csr_a stable, decrement the 4-bit counter each cycle, and go to RACK when the counter is 0.
REQ-023 On entering RACK, SHALL register wb_dat_o <= csr_di; RACK SHALL last one cycle with wb_ack_o=1, then return to IDLE.
REQ-024 Read latency strobe-sample to ack SHALL be READ_WAIT+1 cycles.
REQ-025 wb_ack_o SHALL be a single-cycle pulse, asserted no earlier than the cycle after the strobe is sampled.
REQ-026 A request SHALL be accepted only in IDLE, so there is always at least one IDLE cycle between transactions.
REQ-027 If wb_cyc_i drops during RWAIT, SHALL return to IDLE with no ack and leave wb_dat_o unchanged.
REQ-028 wb_dat_o SHALL hold the last read value until the next completed read.
REQ-029 csr_a and csr_do SHALL hold their values after a transaction ends.
REQ-030 csr_we SHALL be 1 only in WRITE.
REQ-031 wb_sel_i SHALL be ignored; every write is a full 32-bit word write.
REQ-032 wb_adr_i bits above CSR_AW+1 and bits [1:0] SHALL be ignored; upstream address decode selects this slave.
REQ-033 wb_cti_i SHALL be ignored; burst beats SHALL each be handled as classic single transfers with full latency.
REQ-034 wb_stb_i without wb_cyc_i SHALL be ignored.

Reset
REQ-035 Asserting sys_rst_n=0 SHALL immediately, without a clock edge, force state IDLE and clear the counter.
REQ-036 Asserting sys_rst_n=0 SHALL immediately force wb_ack_o=0, csr_we=0, csr_a=0, csr_do=0 and wb_dat_o=0.
REQ-037 Reset mid-transaction SHALL abort it, with no ack and no csr_we pulse after reset asserts.
REQ-038 The first request SHALL be accepted on the first rising edge with sys_rst_n=1.

Verification
REQ-039 Write: adr=0x0000_0010, dat=0xDEADBEEF, we=1 -> next cycle csr_a=4, csr_do=0xDEADBEEF, csr_we=1 and ack=1 for exactly one cycle.
REQ-040 Read, READ_WAIT=2: adr=0x0000_0020, csr_di=0x12345678 -> csr_a=8, ack 3 cycles after the strobe is sampled, wb_dat_o=0x12345678, csr_we never set.
REQ-041 Back-to-back: write then read held on the bus continuously -> one IDLE cycle between the two acks; ack for write at +1 and for read at +1+1+3.
REQ-042 Abort: read started, wb_cyc_i dropped after 1 RWAIT cycle -> no ack, wb_dat_o keeps its previous value, next request accepted normally.
REQ-043 Reset: sys_rst_n pulled low during WRITE/RWAIT between clock edges -> all outputs 0 immediately, no ack until a new request after release.
REQ-044 Parameter sweep: READ_WAIT=1 and 15 -> read ack latency of 2 and 16 cycles respectively; wb_sel_i=4'b0001 write still writes a full word.
